// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// IF looks up combinationally; EX writes resolved outcomes back and gets a flush request.
module branch_predictor_btb #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MODE     = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              upd_mispredict,
  input  logic              flush_tbl,
  output logic [31:0]       branch_cnt,
  output logic [31:0]       mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] CtrWeakNt = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CtrWeakT  = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CtrMax    = '1;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  logic             unused_pc_lsbs;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
  // Byte offset within the instruction word plays no part in indexing.
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  always_comb begin
    pred_hit    = (MODE == 1) && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = pred_hit && ctr_q[f_idx][CTR_BITS-1];
    pred_target = pred_taken ? target_q[f_idx] : fetch_pc + ADDR_W'(4);
  end

  always_comb begin
    u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    upd_mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                   (upd_taken && (upd_pred_target != upd_target)));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWeakNt;
      end
    end else if (flush_tbl) begin
      // Flush takes priority over a same-cycle update; only valid bits are cleared.
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid && (MODE == 1)) begin
      if (u_hit) begin
        if (upd_taken) begin
          target_q[u_idx] <= upd_target;
          if (ctr_q[u_idx] != CtrMax) ctr_q[u_idx] <= ctr_q[u_idx] + CTR_BITS'(1);
        end else if (ctr_q[u_idx] != '0) begin
          ctr_q[u_idx] <= ctr_q[u_idx] - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target;
        ctr_q[u_idx]    <= CtrWeakT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_valid) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (upd_mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
- Replaces resolve-in-EX/flush-always branch handling. IF looks up the fetch PC combinationally to choose the next PC. EX sends resolved outcomes back as updates.
- Raises a mispredict flag that drives IF/ID and ID/EX flushes, and keeps performance counters.

Parameters:
- ENTRIES, 16, table depth; power of two, >= 2; IDX_W = log2(ENTRIES).
- CTR_BITS, 2, direction counter width; >= 1.
- ADDR_W, 32, PC width. TAG_W = ADDR_W - IDX_W - 2 (local).
- MODE, 1: 1 = dynamic prediction; 0 = static not-taken, table frozen, stats still count.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- fetch_pc  in  ADDR_W  IF-stage PC to predict.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  resolved conditional branch present in EX this cycle.
- upd_pc  in  ADDR_W  PC of resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe with this branch.
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe.
- upd_mispredict  out  1  flush request.
- flush_tbl  in  1  synchronous invalidate of all entries.
- branch_cnt  out  32  resolved branches.
- mispredict_cnt  out  32  mispredictions.

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Entry storage: valid, tag, target, ctr[CTR_BITS-1:0].
- Lookup (combinational, zero latency):
  - pred_hit = MODE==1 && valid[idx] && tag match.
  - pred_taken = pred_hit && ctr[idx] MSB.
  - pred_target = pred_taken ? target[idx] : fetch_pc+4, modulo 2^ADDR_W.
- upd_mispredict (combinational):
  - = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_target != upd_target)).
  - upd_pred_target is compared only when upd_taken=1.
- Update (rising edge, upd_valid=1, MODE==1, flush_tbl=0):
  - Hit: ctr +1 if taken, -1 if not; saturates at 2^CTR_BITS-1 and at 0. target <= upd_target only if taken.
  - Miss and taken: allocate/overwrite: valid=1, tag, target=upd_target, ctr=2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no change; an aliasing entry is not evicted.
- Read-during-write to the same idx: lookup returns pre-edge contents; the new contents are visible the next cycle.
- flush_tbl=1: all valid <= 0 at the edge.
  - flush_tbl with upd_valid in the same cycle: the flush wins and no allocation or counter change occurs.
  - Stats still count.
- Stats (every edge with upd_valid=1, any MODE):
  - branch_cnt +1.
  - mispredict_cnt +1 if upd_mispredict.
  - Both saturate at 32'hFFFFFFFF; no wrap.
- Reset (async, immediate):
  - all valid=0, ctr=2^(CTR_BITS-1)-1 (weakly not-taken), tags/targets=0, counters=0.
  - Outputs then: pred_hit=0, pred_taken=0, pred_target=fetch_pc+4, upd_mispredict follows inputs.
  - Reset mid-update discards that update.
- No stall input: the caller gates upd_valid with its pipeline enable, so each branch is counted exactly once.

Test Plan:
(ENTRIES=16, CTR_BITS=2, MODE=1)
1. After reset, fetch_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; branch_cnt=0, mispredict_cnt=0.
2. Update pc=0x40, taken=1, target=0x100, pred_taken=0 -> upd_mispredict=1 that cycle; then branch_cnt=1, mispredict_cnt=1; lookup 0x40 -> hit=1, taken=1 (ctr=2), target=0x100.
3. Counter saturation on 0x40:
   - Three not-taken updates -> ctr 2->1->0->0; lookup taken=0, target=0x44, hit=1.
   - Four taken updates -> ctr 1,2,3,3; target stays 0x100.
4. Aliasing: 0x40 allocated, then update pc=0x80 (same idx 0), taken, target 0x200 -> lookup 0x80 hit, target=0x200; lookup 0x40 miss. A not-taken update to 0xC0 leaves the 0x80 entry intact.
5. flush_tbl=1 with upd_valid=1 (pc=0x44, taken) in the same cycle -> next cycle all lookups miss, 0x44 not allocated, branch_cnt incremented; correct prediction (pred_taken=1, matching target) -> mispredict_cnt unchanged.
6. MODE=0 instance: taken update on 0x40 then lookup -> hit=0, taken=0, target=0x44; counts still increment. Separately, assert nRST mid-cycle -> counters and outputs reset immediately, without waiting for a clock edge.
